// File: rtl/perf_ovf_irq.sv
// Overflow tracker for the generic performance counters: latches per-counter OF flags on wrap
// and drives the local-counter-overflow interrupt (LCOFI) pending bit, cause index and total.
module perf_ovf_irq #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned CntWidth    = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            debug_mode_i,
  input  logic [NumCounters*CntWidth-1:0] cnt_val_i,
  input  logic [NumCounters-1:0]          cnt_inc_i,
  input  logic [NumCounters-1:0]          cnt_wr_i,
  input  logic                            of_we_i,
  input  logic [NumCounters-1:0]          of_wdata_i,
  output logic [NumCounters-1:0]          of_o,
  input  logic                            lcofip_clr_i,
  input  logic                            lcofie_i,
  output logic                            lcofip_o,
  output logic                            irq_o,
  output logic [2:0]                      ovf_idx_o,
  output logic [7:0]                      ovf_total_o
);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e                 state_q;
  logic [NumCounters-1:0] of_q, of_d;
  logic [NumCounters-1:0] wrap, qual;
  logic                   any_qual;
  logic [2:0]             qual_idx;
  logic [2:0]             idx_q;
  logic [7:0]             total_q;

  always_comb begin
    wrap = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      wrap[i] = cnt_inc_i[i] & (cnt_val_i[i*CntWidth +: CntWidth] == {CntWidth{1'b1}}) &
                ~cnt_wr_i[i] & ~debug_mode_i;
    end
  end

  // A wrap on a counter whose OF is already set is silent.
  assign qual     = wrap & ~of_q;
  assign any_qual = |qual;

  // Walk from the top so the lowest set index wins.
  always_comb begin
    qual_idx = '0;
    for (int i = int'(NumCounters) - 1; i >= 0; i--) begin
      if (qual[i]) qual_idx = 3'(i);
    end
  end

  // Hardware set wins over a same-cycle software write so no overflow is lost.
  always_comb begin
    of_d = of_q;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (qual[i])      of_d[i] = 1'b1;
      else if (of_we_i) of_d[i] = of_wdata_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      of_q    <= '0;
      idx_q   <= '0;
      total_q <= '0;
    end else begin
      of_q <= of_d;
      if (any_qual && (total_q != 8'hFF)) total_q <= total_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          if (any_qual) begin
            state_q <= StPend;
            idx_q   <= qual_idx;
          end
        end
        StPend: begin
          // First cause is retained until software clears; a clear racing a new
          // overflow keeps the interrupt pending with the new cause.
          if (lcofip_clr_i) begin
            if (any_qual) idx_q <= qual_idx;
            else          state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign of_o        = of_q;
  assign lcofip_o    = (state_q == StPend);
  assign irq_o       = lcofip_o & lcofie_i;
  assign ovf_idx_o   = idx_q;
  assign ovf_total_o = total_q;

endmodule

// File: tb/tb_perf_ovf_irq.sv
// Directed self-checking bench for perf_ovf_irq with hand-computed expectations.
module tb_perf_ovf_irq;

  localparam int unsigned NumCounters = 6;
  localparam int unsigned CntWidth    = 64;

  logic                            clk_i = 1'b0;
  logic                            rst_ni;
  logic                            debug_mode_i;
  logic [NumCounters*CntWidth-1:0] cnt_val_i;
  logic [NumCounters-1:0]          cnt_inc_i;
  logic [NumCounters-1:0]          cnt_wr_i;
  logic                            of_we_i;
  logic [NumCounters-1:0]          of_wdata_i;
  logic [NumCounters-1:0]          of_o;
  logic                            lcofip_clr_i;
  logic                            lcofie_i;
  logic                            lcofip_o;
  logic                            irq_o;
  logic [2:0]                      ovf_idx_o;
  logic [7:0]                      ovf_total_o;

  int n_cmp = 0;
  int n_err = 0;

  perf_ovf_irq #(
    .NumCounters(NumCounters),
    .CntWidth   (CntWidth)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .debug_mode_i(debug_mode_i),
    .cnt_val_i   (cnt_val_i),
    .cnt_inc_i   (cnt_inc_i),
    .cnt_wr_i    (cnt_wr_i),
    .of_we_i     (of_we_i),
    .of_wdata_i  (of_wdata_i),
    .of_o        (of_o),
    .lcofip_clr_i(lcofip_clr_i),
    .lcofie_i    (lcofie_i),
    .lcofip_o    (lcofip_o),
    .irq_o       (irq_o),
    .ovf_idx_o   (ovf_idx_o),
    .ovf_total_o (ovf_total_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then drop every single-cycle stimulus back to idle.
  task automatic step();
    @(posedge clk_i);
    #1;
    cnt_val_i    = '0;
    cnt_inc_i    = '0;
    cnt_wr_i     = '0;
    of_we_i      = 1'b0;
    of_wdata_i   = '0;
    lcofip_clr_i = 1'b0;
    debug_mode_i = 1'b0;
  endtask

  // Present all-ones with an increment on every counter in mask, then take the edge.
  task automatic wrap(input logic [NumCounters-1:0] mask);
    for (int i = 0; i < int'(NumCounters); i++) begin
      cnt_val_i[i*CntWidth +: CntWidth] = mask[i] ? {CntWidth{1'b1}} : '0;
    end
    cnt_inc_i = mask;
    step();
  endtask

  task automatic clear_of();
    of_we_i    = 1'b1;
    of_wdata_i = '0;
    step();
  endtask

  task automatic expect_all(input string tag, input logic [5:0] of_e, input logic pend_e,
                            input logic [2:0] idx_e, input logic [7:0] tot_e);
    check({tag, ".of"},    64'(of_o),        64'(of_e));
    check({tag, ".pend"},  64'(lcofip_o),    64'(pend_e));
    check({tag, ".idx"},   64'(ovf_idx_o),   64'(idx_e));
    check({tag, ".total"}, 64'(ovf_total_o), 64'(tot_e));
  endtask

  initial begin
    rst_ni       = 1'b0;
    cnt_val_i    = '0;
    cnt_inc_i    = '0;
    cnt_wr_i     = '0;
    of_we_i      = 1'b0;
    of_wdata_i   = '0;
    lcofip_clr_i = 1'b0;
    debug_mode_i = 1'b0;
    lcofie_i     = 1'b1;
    #2;
    expect_all("reset", 6'b0, 1'b0, 3'd0, 8'd0);
    check("reset.irq", 64'(irq_o), 64'd0);
    #1 rst_ni = 1'b1;
    step();

    wrap(6'b000100);
    expect_all("basic", 6'b000100, 1'b1, 3'd2, 8'd1);
    check("basic.irq", 64'(irq_o), 64'd1);

    wrap(6'b000100);
    expect_all("silent", 6'b000100, 1'b1, 3'd2, 8'd1);

    lcofip_clr_i = 1'b1;
    step();
    expect_all("clr", 6'b000100, 1'b0, 3'd2, 8'd1);

    wrap(6'b000100);
    expect_all("silent_idle", 6'b000100, 1'b0, 3'd2, 8'd1);

    clear_of();
    check("swclr.of", 64'(of_o), 64'd0);
    wrap(6'b000100);
    expect_all("rewrap", 6'b000100, 1'b1, 3'd2, 8'd2);

    lcofip_clr_i = 1'b1;
    of_we_i      = 1'b1;
    of_wdata_i   = '0;
    step();
    expect_all("clr_both", 6'b000000, 1'b0, 3'd2, 8'd2);

    wrap(6'b010010);
    expect_all("simul", 6'b010010, 1'b1, 3'd1, 8'd3);

    lcofip_clr_i = 1'b1;
    wrap(6'b100000);
    expect_all("clr_race", 6'b110010, 1'b1, 3'd5, 8'd4);

    // Hardware set on bit 0 beats the software write; other bits take the write.
    of_we_i    = 1'b1;
    of_wdata_i = 6'b000000;
    wrap(6'b000001);
    expect_all("hw_prio", 6'b000001, 1'b1, 3'd5, 8'd5);

    clear_of();
    debug_mode_i = 1'b1;
    wrap(6'b001000);
    expect_all("debug", 6'b000000, 1'b1, 3'd5, 8'd5);

    cnt_wr_i = 6'b001000;
    wrap(6'b001000);
    expect_all("cnt_wr", 6'b000000, 1'b1, 3'd5, 8'd5);

    // One below all-ones must not count as a wrap.
    cnt_val_i[3*CntWidth +: CntWidth] = {{(CntWidth-1){1'b1}}, 1'b0};
    cnt_inc_i = 6'b001000;
    step();
    expect_all("near_ones", 6'b000000, 1'b1, 3'd5, 8'd5);

    lcofie_i = 1'b0;
    #1;
    check("irq_gate.irq", 64'(irq_o), 64'd0);
    check("irq_gate.pend", 64'(lcofip_o), 64'd1);
    lcofie_i = 1'b1;
    #1;
    check("irq_ungate.irq", 64'(irq_o), 64'd1);

    for (int k = 0; k < 249; k++) begin
      wrap(6'b000001);
      clear_of();
    end
    check("sat.254", 64'(ovf_total_o), 64'd254);
    for (int k = 0; k < 51; k++) begin
      wrap(6'b000001);
      clear_of();
    end
    check("sat.255", 64'(ovf_total_o), 64'hFF);
    check("sat.pend", 64'(lcofip_o), 64'd1);

    wrap(6'b000100);
    check("mid.pend", 64'(lcofip_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    expect_all("async_rst", 6'b0, 1'b0, 3'd0, 8'd0);
    check("async_rst.irq", 64'(irq_o), 64'd0);
    #1 rst_ni = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
